// File: rtl/dcache_line_mover_if.sv
// AXI-style burst bus between the line mover (master) and external memory (slave).
// Only the fields the mover drives or consumes are carried.
interface dcache_line_mover_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic                  arvalid;
   logic                  arready;
   logic [BEAT_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  rlast;
   logic                  rready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic                  awvalid;
   logic                  awready;
   logic [BEAT_WIDTH-1:0] wdata;
   logic                  wvalid;
   logic                  wlast;
   logic                  wready;
   logic                  bvalid;
   logic [1:0]            bresp;
   logic                  bready;

   modport master (
      output araddr, arlen, arvalid, input arready,
      input  rdata, rvalid, rlast, output rready,
      output awaddr, awlen, awvalid, input awready,
      output wdata, wvalid, wlast, input wready,
      input  bvalid, bresp, output bready
   );

   modport slave (
      input  araddr, arlen, arvalid, output arready,
      output rdata, rvalid, rlast, input rready,
      input  awaddr, awlen, awvalid, output awready,
      input  wdata, wvalid, wlast, output wready,
      output bvalid, bresp, input bready
   );
endinterface

// File: rtl/dcache_line_mover.sv
// Moves one whole cache line per request between the data cache and the AXI bus:
// fills assemble an INCR read burst into o_block, writebacks split a block into a write burst.
module dcache_line_mover #(
   parameter int BLOCK_WIDTH = 256,
   parameter int BEAT_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   i_start_read,
   input  logic                   i_start_write,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic [BLOCK_WIDTH-1:0] i_block,
   output logic [BLOCK_WIDTH-1:0] o_block,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err,
   dcache_line_mover_if.master    axi
);
   localparam int BEATS = BLOCK_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BLOCK_WIDTH-1:0] wblock_q, wblock_d;
   logic [BLOCK_WIDTH-1:0] block_q, block_d;
   logic [CNT_W-1:0]       beat_q, beat_d;
   logic                   err_q, err_d;

   logic                   last_beat;
   logic                   ar_valid, r_ready, aw_valid, w_valid, b_ready, done;
   logic [BEAT_WIDTH-1:0]  wwords [BEATS];

   assign last_beat = (beat_q == CNT_W'(BEATS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_wword
         assign wwords[gi] = wblock_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wblock_d = wblock_q;
      block_d  = block_q;
      beat_d   = beat_q;
      err_d    = err_q;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A simultaneous read request stays pending on its held level.
            if (i_start_write || i_start_read) begin
               addr_d             = i_addr;
               addr_d[OFF_W-1:0]  = '0;
               err_d              = 1'b0;
               beat_d             = '0;
               if (i_start_write) begin
                  wblock_d = i_block;
                  state_d  = S_AW;
               end else begin
                  state_d  = S_AR;
               end
            end
         end
         S_AR: begin
            ar_valid = 1'b1;
            if (axi.arready) state_d = S_R;
         end
         S_R: begin
            r_ready = 1'b1;
            if (axi.rvalid) begin
               block_d[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] = axi.rdata;
               if (axi.rlast != last_beat) err_d = 1'b1;
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = S_DONE;
            end
         end
         S_AW: begin
            aw_valid = 1'b1;
            if (axi.awready) state_d = S_W;
         end
         S_W: begin
            w_valid = 1'b1;
            if (axi.wready) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = S_B;
            end
         end
         S_B: begin
            b_ready = 1'b1;
            if (axi.bvalid) begin
               if (axi.bresp != 2'b00) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wblock_q <= '0;
         block_q  <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wblock_q <= wblock_d;
         block_q  <= block_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
      end
   end

   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'(BEATS - 1);
   assign axi.arvalid = ar_valid;
   assign axi.rready  = r_ready;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'(BEATS - 1);
   assign axi.awvalid = aw_valid;
   assign axi.wdata   = wwords[beat_q];
   assign axi.wvalid  = w_valid;
   assign axi.wlast   = w_valid & last_beat;
   assign axi.bready  = b_ready;

   assign o_block = block_q;
   assign o_busy  = (state_q != S_IDLE);
   assign o_done  = done;
   assign o_err   = err_q;
endmodule

// File: tb/tb_dcache_line_mover.sv
// Scoreboard bench for dcache_line_mover: a randomly stalling memory model drives the bus,
// expected addresses/beats/completions are queued at issue and checked by a separate monitor.
module tb_dcache_line_mover;
   localparam int BW    = 256;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int BEATS = BW / DW;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          start_rd = 1'b0;
   logic          start_wr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [BW-1:0] blk = '0;
   logic [BW-1:0] o_block;
   logic          busy, done, err;

   always #5 clk = ~clk;

   dcache_line_mover_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(DW)) axi ();

   dcache_line_mover #(.BLOCK_WIDTH(BW), .BEAT_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .arst          (arst),
      .i_start_read  (start_rd),
      .i_start_write (start_wr),
      .i_addr        (addr),
      .i_block       (blk),
      .o_block       (o_block),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err),
      .axi           (axi.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic [BW-1:0] blk;
      logic          err;
   } done_t;

   logic [AW-1:0] ar_q [$];
   logic [AW-1:0] aw_q [$];
   logic [DW:0]   w_q [$];
   done_t         done_q [$];
   logic [BW-1:0] last_fill = '0;

   // memory model configuration, stable for the duration of one transfer
   logic [DW-1:0] rd_words [BEATS];
   int            rlast_at = BEATS - 1;
   logic [1:0]    bresp_cfg = 2'b00;
   int            stall_pct = 0;
   int            r_idx = 0;
   int            b_hs_cyc = 0;
   int            acc_cyc = 0;
   int            done_cyc = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   function automatic bit go();
      if (stall_pct == 0) return 1'b1;
      return ($urandom_range(0, 99) >= stall_pct);
   endfunction

   // memory slave: decides its outputs at the falling edge for the next rising edge
   initial begin
      bit r_active, b_pend, ar_hs, w_fin;
      r_active = 0; b_pend = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rlast = 0;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
      forever begin
         @(negedge clk);
         if (arst) begin
            r_active = 0; b_pend = 0; r_idx = 0;
            axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
         end else begin
            axi.arready = go();
            ar_hs = axi.arvalid && axi.arready;
            if (r_active) begin
               axi.rvalid = go();
               axi.rdata  = rd_words[r_idx];
               axi.rlast  = (r_idx == rlast_at);
               if (axi.rvalid && axi.rready) begin
                  r_idx++;
                  if (r_idx == BEATS) r_active = 0;
               end
            end else begin
               axi.rvalid = 0;
               axi.rlast  = 0;
            end
            if (ar_hs) begin
               r_active = 1;
               r_idx    = 0;
            end
            axi.awready = go();
            axi.wready  = go();
            w_fin = axi.wvalid && axi.wready && axi.wlast;
            if (b_pend) begin
               axi.bvalid = go();
               axi.bresp  = bresp_cfg;
               if (axi.bvalid && axi.bready) begin
                  b_pend   = 0;
                  b_hs_cyc = cyc;
               end
            end else begin
               axi.bvalid = 0;
            end
            if (w_fin) b_pend = 1;
         end
      end
   end

   // monitor: pops the scoreboard whenever the DUT presents a handshake or completion
   initial forever begin
      @(negedge clk);
      #1;
      if (!arst) begin
         if (axi.arvalid && axi.arready) begin
            if (ar_q.size() == 0) fail_now("ar_unexpected");
            else begin
               check("araddr", BW'(axi.araddr), BW'(ar_q.pop_front()));
               check("arlen", BW'(axi.arlen), BW'(BEATS - 1));
            end
         end
         if (axi.awvalid && axi.awready) begin
            if (aw_q.size() == 0) fail_now("aw_unexpected");
            else begin
               check("awaddr", BW'(axi.awaddr), BW'(aw_q.pop_front()));
               check("awlen", BW'(axi.awlen), BW'(BEATS - 1));
            end
         end
         if (axi.wvalid && axi.wready) begin
            if (w_q.size() == 0) fail_now("w_unexpected");
            else check("wlast_wdata", BW'({axi.wlast, axi.wdata}), BW'(w_q.pop_front()));
         end
         if (done) begin
            if (done_q.size() == 0) fail_now("done_unexpected");
            else begin
               done_t e;
               e = done_q.pop_front();
               check("done_block", o_block, e.blk);
               check("done_err", BW'(err), BW'(e.err));
               $display("txn done at cycle %0d block=%0h err=%0b", cyc, o_block, err);
            end
         end
      end
   end

   // reference model: what one transfer must produce, from the memory config and request
   task automatic push_exp(input bit is_wr, input logic [AW-1:0] a, input logic [BW-1:0] b);
      logic [AW-1:0] la;
      logic [BW-1:0] fill;
      la = a & ~AW'(BW / 8 - 1);
      if (is_wr) begin
         aw_q.push_back(la);
         for (int k = 0; k < BEATS; k++) w_q.push_back({k == BEATS - 1, b[k*DW +: DW]});
         done_q.push_back('{blk: last_fill, err: (bresp_cfg != 2'b00)});
      end else begin
         for (int k = 0; k < BEATS; k++) fill[k*DW +: DW] = rd_words[k];
         ar_q.push_back(la);
         last_fill = fill;
         done_q.push_back('{blk: fill, err: (rlast_at != BEATS - 1)});
      end
   endtask

   task automatic start_req(input bit is_wr, input logic [AW-1:0] a, input logic [BW-1:0] b);
      push_exp(is_wr, a, b);
      addr = a;
      blk  = b;
      if (is_wr) start_wr = 1'b1; else start_rd = 1'b1;
      acc_cyc = cyc;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 3000);
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got no o_done, expected one within 3000 cycles");
      end
      done_cyc = cyc;
   endtask

   task automatic finish_req();
      wait_done();
      start_rd = 1'b0;
      start_wr = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [BW-1:0] idx_block();
      logic [BW-1:0] r;
      for (int k = 0; k < BEATS; k++) r[k*DW +: DW] = DW'(k);
      return r;
   endfunction

   function automatic logic [BW-1:0] rand_block();
      logic [BW-1:0] r;
      for (int k = 0; k < BEATS; k++) r[k*DW +: DW] = $urandom;
      return r;
   endfunction

   function automatic logic [7:0] bus_idle_flags();
      return {busy, done, err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
   endfunction

   initial begin
      logic [BW-1:0] b;
      bit ok;
      for (int k = 0; k < BEATS; k++) rd_words[k] = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_flags", BW'(bus_idle_flags()), '0);
      check("reset_block", o_block, '0);
      arst = 1'b0;
      @(negedge clk);

      // full-speed fill, rdata = beat index
      stall_pct = 0;
      rlast_at  = BEATS - 1;
      for (int k = 0; k < BEATS; k++) rd_words[k] = DW'(k);
      start_req(0, 32'h1000_0047, '0);
      finish_req();
      check("fill_latency", BW'(done_cyc - acc_cyc), BW'(10));
      check("fill_block_idle", o_block, idx_block());
      check("fill_err", BW'(err), '0);

      // writeback of word k = k with random wready stalls
      stall_pct = 40;
      start_req(1, 32'h2000_0020, idx_block());
      finish_req();
      check("done_after_bvalid", BW'(done_cyc - b_hs_cyc), BW'(1));
      check("fill_block_held", o_block, idx_block());

      // both starts together: writeback first, then the still-held fill to the same address
      stall_pct = 0;
      for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
      b = rand_block();
      push_exp(1, 32'h3000_0100, b);
      push_exp(0, 32'h3000_0100, '0);
      addr = 32'h3000_0100;
      blk = b;
      start_wr = 1'b1;
      start_rd = 1'b1;
      @(negedge clk);
      check("both_aw_first", BW'({axi.awvalid, axi.arvalid}), BW'(2'b10));
      wait_done();
      start_wr = 1'b0;
      wait_done();
      start_rd = 1'b0;
      @(negedge clk);

      // fill with early rlast on beat 5: all beats consumed, error sticky until next accept
      stall_pct = 20;
      rlast_at  = 5;
      for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
      start_req(0, 32'h4000_0000, '0);
      finish_req();
      repeat (3) @(negedge clk);
      check("rlast_err_sticky", BW'(err), BW'(1));
      rlast_at = BEATS - 1;
      start_req(0, 32'h4000_0040, '0);
      @(negedge clk);
      check("err_clear_on_accept", BW'({busy, err}), BW'(2'b10));
      finish_req();

      // SLVERR write response
      bresp_cfg = 2'b10;
      start_req(1, 32'h5000_0060, rand_block());
      finish_req();
      @(negedge clk);
      check("bresp_err_sticky", BW'(err), BW'(1));
      bresp_cfg = 2'b00;
      start_req(1, 32'h5000_0080, rand_block());
      @(negedge clk);
      check("bresp_err_clear", BW'(err), '0);
      finish_req();

      // reset while beat 3 of a fill is on the bus
      stall_pct = 0;
      for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
      start_req(0, 32'h6000_0000, '0);
      void'(done_q.pop_back());
      last_fill = '0;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         #2;
         if (r_idx == 4) ok = 1;
      end
      check("reached_beat3", BW'(ok), BW'(1));
      arst = 1'b1;
      start_rd = 1'b0;
      @(negedge clk);
      #2;
      check("abort_flags", BW'(bus_idle_flags()), '0);
      check("abort_block", o_block, '0);
      arst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
      start_req(0, 32'h6000_0040, '0);
      finish_req();

      // randomized mix of fills and writebacks
      for (int t = 0; t < 24; t++) begin
         int ra;
         stall_pct = $urandom_range(0, 60);
         ra = $urandom_range(0, 11);
         rlast_at = (ra > BEATS) ? BEATS - 1 : ra;
         bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         for (int k = 0; k < BEATS; k++) rd_words[k] = $urandom;
         start_req($urandom_range(0, 1) == 1, $urandom, rand_block());
         finish_req();
      end
      rlast_at = BEATS - 1;

      repeat (3) @(negedge clk);
      check("queues_drained", BW'(ar_q.size() + aw_q.size() + w_q.size() + done_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
